mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage RISC-V pipeline. It sits between the EX/MEM and MEM/WB pipeline registers and consumes the EX/MEM outputs: ALU result as address, store data, memory control bits, and destination register. It drives a valid/ready data-memory port with variable response latency and formats byte, halfword and word loads and stores. It also asserts `stall` so that upstream stages hold while an access is outstanding.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_alu_out` in 32: effective address, or result for non-memory ops.
- `in_mem_data` in 32: store data (rs2), unaligned in the low bits.
- `in_funct3` in 3: access size and signedness.
- `in_mem_read`, `in_mem_write` in 1 each: load / store request; never both 1.
- `in_rd` in 5; `in_mem_to_reg` in 1; `in_write_enable` in 1.
- `stall` out 1: hold EX/MEM and all earlier stages this cycle.
- `misaligned` out 1: one-cycle pulse on a misaligned access.
- `dmem_req_valid` out 1; `dmem_req_ready` in 1.
- `dmem_req_addr` out 32: word-aligned (bits [1:0] = 0).
- `dmem_req_we` out 1; `dmem_req_wdata` out 32; `dmem_req_wstrb` out 4.
- `dmem_rsp_valid` in 1; `dmem_rsp_rdata` in 32.
- `out_alu_out` out 32; `out_mem_rdata` out 32 (extended load data).
- `out_rd` out 5; `out_mem_to_reg` out 1; `out_write_enable` out 1.

## Operation
- A memory op is `in_mem_read | in_mem_write`.
- Non-memory ops pass through combinationally with `stall=0` and no request.
- funct3 encodings:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other encoding on a memory op is treated as LW/SW.
- Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]≠0. In that case:
  - no request is issued; `misaligned=1` and `stall=0` for that cycle;
  - `out_write_enable` is forced to 0.
- Store formatting:
  - `wdata` = byte or halfword replicated across lanes.
  - `wstrb`: SB = 0001<<addr[1:0]; SH = 0011<<{addr[1],0}; SW = 1111.
  - Loads drive `wstrb=0` and `we=0`.
- Load formatting:
  - Select the byte or halfword by addr[1:0] from the captured word.
  - Sign- or zero-extend per funct3.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE:
    - on an aligned memory op, drive `req_valid=1`;
    - if `req_ready`: load → WAIT, store → DONE;
    - otherwise → REQ.
  - REQ: hold `req_valid` with stable addr, we, wdata and wstrb until `req_ready`; then load → WAIT, store → DONE.
  - WAIT: on `rsp_valid`, capture `rsp_rdata` into `rdata_q` and go → DONE. `req_valid=0`.
  - DONE:
    - `stall=0`, `req_valid=0`;
    - outputs reflect the completed op (`out_mem_rdata` from `rdata_q`);
    - go → IDLE unconditionally, so the held op is never reissued.
- `stall` = aligned memory op present AND state ≠ DONE. This holds in IDLE, REQ and WAIT.
- `out_*` control and `out_alu_out` pass through combinationally from `in_*`. `out_mem_rdata` = extend(`rdata_q`).
- Stores never wait for a response. `dmem_rsp_valid` is ignored outside WAIT.

## Timing
- Reset values: state = IDLE, `rdata_q` = 0.
- Outputs after reset with idle inputs: `stall=0`, `misaligned=0`, and `dmem_req_valid`, `dmem_req_we` and `dmem_req_wstrb` all 0.
- Load with ready=1 and a response the next cycle: 3 cycles (IDLE issue, WAIT, DONE). `stall` is high for 2 cycles.
- Store with ready=1: 2 cycles (IDLE issue, DONE). `stall` is high for 1 cycle.
- Each cycle of `req_ready=0` or missing `rsp_valid` adds one stall cycle.
- `rsp_valid` in the same cycle as acceptance is not possible; a response is earliest one cycle after acceptance.
- Reset mid-operation returns to IDLE and abandons the outstanding access. A later `rsp_valid` is ignored.
- Request fields must not change while `req_valid=1 && !req_ready`. Upstream guarantees this by holding inputs under `stall`.

## Structure
- Package `mem_pkg`:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the `mem_state_t` enum (IDLE, REQ, WAIT, DONE).
- Sub-module `lsu_align` (combinational):
  - generates store `wdata`/`wstrb`;
  - extracts and extends load data;
  - detects misalignment.
- `mem_stage` holds the FSM, the `rdata_q` capture register, and the stall/handshake logic.

## Test plan
- SB addr 0x1003, data 0x000000AB, ready=1 → `wdata` 0xABABABAB, `wstrb` 1000, addr 0x1000; stall 1 cycle; next cycle DONE with `stall=0`.
- LB addr 0x2001, memory word 0x00008000 with response 1 cycle after acceptance → `out_mem_rdata` 0xFFFFFF80. LBU on the same access → 0x00000080. `stall` high 2 cycles.
- LH addr 0x2002, memory word 0x8001_1234 → 0xFFFF8001. LHU → 0x00008001.
- LW with `req_ready` low for 3 cycles and `rsp_valid` 2 cycles after acceptance → `req_valid` and addr held stable; `stall` high 6 cycles; data 0xDEADBEEF captured.
- SW addr 0x3002 → `misaligned` pulses 1 cycle, no `req_valid`, `stall=0`, `out_write_enable=0`.
- Reset asserted during WAIT, then `rsp_valid` arrives → state IDLE, `rdata_q`=0, response ignored, `stall=0` with no memory op present.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: funct3 access codes, FSM states
// and the access-size decode used by both the aligner and the stage.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } mem_state_t;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord
    } size_e;

    // Unsigned variants only exist for loads; every unknown code falls back to a word.
    function automatic size_e access_size(input logic [2:0] f3, input logic is_store);
        if (f3 == F3_B || (!is_store && f3 == F3_BU)) return SzByte;
        if (f3 == F3_H || (!is_store && f3 == F3_HU)) return SzHalf;
        return SzWord;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication and byte strobes, load lane
// selection with sign/zero extension, and misalignment detection.
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o
);

    size_e       size;
    logic        zero_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign size     = access_size(funct3_i, is_store_i);
    assign zero_ext = !is_store_i && (funct3_i == F3_BU || funct3_i == F3_HU);

    // Pick the addressed byte and halfword lanes out of the captured word.
    always_comb begin
        case (addr_lo_i)
            2'd0:    ld_byte = load_word_i[7:0];
            2'd1:    ld_byte = load_word_i[15:8];
            2'd2:    ld_byte = load_word_i[23:16];
            default: ld_byte = load_word_i[31:24];
        endcase
        ld_half = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];
    end

    // Per-size formatting; the word case is the default for all unknown codes.
    always_comb begin
        wdata_o      = store_data_i;
        wstrb_o      = 4'b1111;
        misaligned_o = (addr_lo_i != 2'b00);
        load_data_o  = load_word_i;
        case (size)
            SzByte: begin
                wdata_o      = {4{store_data_i[7:0]}};
                wstrb_o      = 4'b0001 << addr_lo_i;
                misaligned_o = 1'b0;
                load_data_o  = zero_ext ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            SzHalf: begin
                wdata_o      = {2{store_data_i[15:0]}};
                wstrb_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
                misaligned_o = addr_lo_i[0];
                load_data_o  = zero_ext ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives a valid/ready data-memory port, captures load
// responses and stalls the upstream pipeline until the access has completed.
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_alu_out,
    input  logic [31:0] in_mem_data,
    input  logic [2:0]  in_funct3,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [4:0]  in_rd,
    input  logic        in_mem_to_reg,
    input  logic        in_write_enable,
    output logic        stall,
    output logic        misaligned,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_req_addr,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_wdata,
    output logic [3:0]  dmem_req_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output logic [31:0] out_alu_out,
    output logic [31:0] out_mem_rdata,
    output logic [4:0]  out_rd,
    output logic        out_mem_to_reg,
    output logic        out_write_enable
);

    mem_state_t  state_q;
    logic [31:0] rdata_q;

    logic        mem_op;
    logic        mis_raw;
    logic        aligned_op;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_wstrb;

    lsu_align u_lsu_align (
        .addr_lo_i    (in_alu_out[1:0]),
        .funct3_i     (in_funct3),
        .is_store_i   (in_mem_write),
        .store_data_i (in_mem_data),
        .load_word_i  (rdata_q),
        .wdata_o      (fmt_wdata),
        .wstrb_o      (fmt_wstrb),
        .load_data_o  (out_mem_rdata),
        .misaligned_o (mis_raw)
    );

    assign mem_op     = in_mem_read | in_mem_write;
    assign aligned_op = mem_op & ~mis_raw;
    assign misaligned = mem_op & mis_raw;

    // DONE is the one cycle where a present memory op lets the pipeline advance.
    assign stall          = aligned_op && (state_q != DONE);
    assign dmem_req_valid = aligned_op && (state_q == IDLE || state_q == REQ);
    assign dmem_req_addr  = {in_alu_out[31:2], 2'b00};
    assign dmem_req_we    = dmem_req_valid & in_mem_write;
    assign dmem_req_wdata = fmt_wdata;
    assign dmem_req_wstrb = dmem_req_we ? fmt_wstrb : 4'b0000;

    assign out_alu_out      = in_alu_out;
    assign out_rd           = in_rd;
    assign out_mem_to_reg   = in_mem_to_reg;
    assign out_write_enable = in_write_enable & ~misaligned;

    // Handshake FSM and load-data capture; stores skip WAIT since they get no response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (aligned_op) begin
                        if (dmem_req_ready) state_q <= in_mem_read ? WAIT : DONE;
                        else                state_q <= REQ;
                    end
                end
                REQ: begin
                    if (!aligned_op)         state_q <= IDLE;
                    else if (dmem_req_ready) state_q <= in_mem_read ? WAIT : DONE;
                end
                WAIT: begin
                    if (dmem_rsp_valid) begin
                        rdata_q <= dmem_rsp_rdata;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
